// File: rtl/priority_multi_encoder_if.sv
// Bundle for priority_multi_encoder: the snapshot inputs and the cluster word stream.
// master: the side that latches events and consumes words; slave: the encoder.
interface priority_multi_encoder_if #(
  parameter int unsigned MXPADS     = 768,
  parameter int unsigned MXCNTB     = 3,
  parameter int unsigned MXADRB     = 11,
  parameter int unsigned MXCLUSTERS = 8,
  parameter int unsigned MXPASSB    = 3
);
  localparam int unsigned IdxW = $clog2(MXCLUSTERS) + 1;

  logic                     latch_pulse;
  logic [MXPADS-1:0]        vpfs_in;
  logic [MXPADS*MXCNTB-1:0] cnts_in;
  logic [MXPASSB-1:0]       pass_in;
  logic                     busy;
  logic                     cluster_strobe;
  logic                     cluster_found;
  logic [MXADRB-1:0]        adr;
  logic [MXCNTB-1:0]        cnt;
  logic [IdxW-1:0]          cluster_idx;
  logic                     last;
  logic [MXPASSB-1:0]       pass_out;
  logic                     overflow;

  modport master (
    output latch_pulse, vpfs_in, cnts_in, pass_in,
    input  busy, cluster_strobe, cluster_found, adr, cnt, cluster_idx, last, pass_out, overflow
  );

  modport slave (
    input  latch_pulse, vpfs_in, cnts_in, pass_in,
    output busy, cluster_strobe, cluster_found, adr, cnt, cluster_idx, last, pass_out, overflow
  );
endinterface

// File: rtl/priority_multi_encoder.sv
// Serial multi-cluster priority encoder.
// A latch pulse snapshots the pad flags, counts and pass tag; the encoder then emits one cluster
// word per clock, lowest pad first, up to MXCLUSTERS words per event (one empty word if no pad).
// Optional build macro: PRIORITY_MULTI_OVERFLOW_EN adds the residual-pads overflow flag on the
// last word; without it overflow is tied low.
module priority_multi_encoder #(
  parameter int unsigned MXPADS     = 768,
  parameter int unsigned MXCNTB     = 3,
  parameter int unsigned MXADRB     = 11,
  parameter int unsigned MXCLUSTERS = 8,
  parameter int unsigned MXPASSB    = 3
) (
  input logic                    clock,
  input logic                    reset,
  priority_multi_encoder_if.slave bus
);
  localparam int unsigned IdxW = $clog2(MXCLUSTERS) + 1;

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e                   state_q;
  logic [MXPADS-1:0]        work_q;
  logic [MXPADS*MXCNTB-1:0] cnts_q;
  logic [MXPASSB-1:0]       pass_q;
  logic [IdxW-1:0]          ord_q;

  logic                     busy_q;
  logic                     strobe_q;
  logic                     found_q;
  logic [MXADRB-1:0]        adr_q;
  logic [MXCNTB-1:0]        cnt_q;
  logic [IdxW-1:0]          idx_q;
  logic                     last_q;
  logic [MXPASSB-1:0]       pass_out_q;

  logic [MXPADS-1:0]        first_oh;
  logic [MXPADS-1:0]        rest;
  logic                     any_found;
  logic                     at_limit;
  logic                     is_last;
  logic [MXADRB-1:0]        win_adr;
  logic [MXCNTB-1:0]        win_cnt;

  // Isolate the lowest set pad (x & -x), drop it from the working copy.
  assign first_oh  = work_q & (~work_q + MXPADS'(1));
  assign rest      = work_q & ~first_oh;
  assign any_found = |work_q;
  assign at_limit  = (ord_q == IdxW'(MXCLUSTERS - 1));
  assign is_last   = !any_found || (rest == '0) || at_limit;

  // One-hot to address/count: at most one bit of first_oh is set, so OR-reduction suffices.
  always_comb begin
    win_adr = '0;
    win_cnt = '0;
    for (int unsigned i = 0; i < MXPADS; i++) begin
      if (first_oh[i]) begin
        win_adr = win_adr | MXADRB'(i);
        win_cnt = win_cnt | cnts_q[i*MXCNTB +: MXCNTB];
      end
    end
  end

`ifdef PRIORITY_MULTI_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;
  // Cluster budget used up while pads remain unreported.
  assign ovf_d = at_limit & (|rest);
`endif

  // FSM, snapshot registers and registered output word.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      work_q     <= '0;
      cnts_q     <= '0;
      pass_q     <= '0;
      ord_q      <= '0;
      busy_q     <= 1'b0;
      strobe_q   <= 1'b0;
      found_q    <= 1'b0;
      adr_q      <= '1;
      cnt_q      <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      pass_out_q <= '0;
`ifdef PRIORITY_MULTI_OVERFLOW_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      // Idle word unless a search step below overrides; idx and pass_out hold.
      strobe_q <= 1'b0;
      found_q  <= 1'b0;
      adr_q    <= '1;
      cnt_q    <= '0;
      last_q   <= 1'b0;
`ifdef PRIORITY_MULTI_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
      if (bus.latch_pulse) begin
        // A latch while busy abandons the running event: its in-flight word is dropped.
        state_q <= StSearch;
        busy_q  <= 1'b1;
        work_q  <= bus.vpfs_in;
        cnts_q  <= bus.cnts_in;
        pass_q  <= bus.pass_in;
        ord_q   <= '0;
      end else if (state_q == StSearch) begin
        strobe_q   <= 1'b1;
        found_q    <= any_found;
        adr_q      <= any_found ? win_adr : '1;
        cnt_q      <= win_cnt;
        idx_q      <= ord_q;
        last_q     <= is_last;
        pass_out_q <= pass_q;
        work_q     <= rest;
        ord_q      <= ord_q + IdxW'(1);
`ifdef PRIORITY_MULTI_OVERFLOW_EN
        ovf_q      <= is_last & ovf_d;
`endif
        if (is_last) begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.busy           = busy_q;
  assign bus.cluster_strobe = strobe_q;
  assign bus.cluster_found  = found_q;
  assign bus.adr            = adr_q;
  assign bus.cnt            = cnt_q;
  assign bus.cluster_idx    = idx_q;
  assign bus.last           = last_q;
  assign bus.pass_out       = pass_out_q;
`ifdef PRIORITY_MULTI_OVERFLOW_EN
  assign bus.overflow       = ovf_q;
`else
  assign bus.overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_priority_multi_encoder.sv
// Bench for priority_multi_encoder: table-driven events, hand-written corner sequences and
// randomized events against a list-based reference model.
module tb_priority_multi_encoder;
  localparam int unsigned P  = 768;
  localparam int unsigned C  = 3;
  localparam int unsigned A  = 11;
  localparam int unsigned M  = 8;
  localparam int unsigned PB = 3;
  localparam logic [A-1:0] AllOnes = '1;
`ifdef PRIORITY_MULTI_OVERFLOW_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clock;
  logic reset;

  priority_multi_encoder_if bus_if ();

  priority_multi_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  int checks;
  int errors;

  logic [P-1:0]   vv;
  logic [P*C-1:0] cc;

  int got_adr[$], got_cnt[$], got_found[$], got_idx[$], got_last[$];
  int got_pass[$], got_ovf[$], got_busy[$];
  int exp_adr[$], exp_cnt[$], exp_found[$];
  bit exp_ovf;

  typedef struct {
    int          lo;
    int          hi;
    int          step;
    logic [PB-1:0] pass;
    int          exp_n;
    int          exp_first;
    int          exp_last;
    bit          exp_ovf;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: list the set pads in ascending order and report the first M of them.
  task automatic model(input logic [P-1:0] v, input logic [P*C-1:0] c);
    int pads[$];
    exp_adr.delete(); exp_cnt.delete(); exp_found.delete();
    for (int i = 0; i < int'(P); i++) if (v[i]) pads.push_back(i);
    exp_ovf = (pads.size() > int'(M));
    if (pads.size() == 0) begin
      exp_adr.push_back(int'(AllOnes)); exp_cnt.push_back(0); exp_found.push_back(0);
    end else begin
      for (int k = 0; k < pads.size() && k < int'(M); k++) begin
        exp_adr.push_back(pads[k]);
        exp_cnt.push_back(int'(c[pads[k]*C +: C]));
        exp_found.push_back(1);
      end
    end
  endtask

  task automatic do_latch(input logic [P-1:0] v, input logic [P*C-1:0] c, input logic [PB-1:0] p);
    bus_if.vpfs_in     = v;
    bus_if.cnts_in     = c;
    bus_if.pass_in     = p;
    bus_if.latch_pulse = 1'b1;
    tick();
    bus_if.latch_pulse = 1'b0;
  endtask

  // Entered in the cycle after the latch edge; returns in the last-word cycle.
  task automatic collect(input string tag, input bit scramble);
    bit done;
    got_adr.delete(); got_cnt.delete(); got_found.delete(); got_idx.delete();
    got_last.delete(); got_pass.delete(); got_ovf.delete(); got_busy.delete();
    check({tag, " busy_t1"}, bus_if.busy, 1);
    check({tag, " strobe_t1"}, bus_if.cluster_strobe, 0);
    tick();
    done = 1'b0;
    for (int n = 0; n < int'(M) && !done; n++) begin
      check($sformatf("%s strobe[%0d]", tag, n), bus_if.cluster_strobe, 1);
      if (bus_if.cluster_strobe !== 1'b1) begin
        done = 1'b1;
      end else begin
        got_adr.push_back(int'(bus_if.adr));
        got_cnt.push_back(int'(bus_if.cnt));
        got_found.push_back(int'(bus_if.cluster_found));
        got_idx.push_back(int'(bus_if.cluster_idx));
        got_last.push_back(int'(bus_if.last));
        got_pass.push_back(int'(bus_if.pass_out));
        got_ovf.push_back(int'(bus_if.overflow));
        got_busy.push_back(int'(bus_if.busy));
        if (bus_if.last === 1'b1) done = 1'b1;
        else begin
          if (scramble) for (int j = 0; j < int'(P) / 32; j++) bus_if.vpfs_in[j*32 +: 32] = $urandom();
          tick();
        end
      end
    end
  endtask

  task automatic compare(input string tag, input logic [PB-1:0] p);
    check({tag, " nwords"}, got_adr.size(), exp_adr.size());
    for (int k = 0; k < got_adr.size() && k < exp_adr.size(); k++) begin
      bit lst;
      lst = (k == exp_adr.size() - 1);
      check($sformatf("%s adr[%0d]", tag, k), got_adr[k], exp_adr[k]);
      check($sformatf("%s cnt[%0d]", tag, k), got_cnt[k], exp_cnt[k]);
      check($sformatf("%s found[%0d]", tag, k), got_found[k], exp_found[k]);
      check($sformatf("%s idx[%0d]", tag, k), got_idx[k], k);
      check($sformatf("%s last[%0d]", tag, k), got_last[k], lst);
      check($sformatf("%s busy[%0d]", tag, k), got_busy[k], !lst);
      check($sformatf("%s pass[%0d]", tag, k), got_pass[k], p);
      check($sformatf("%s ovf[%0d]", tag, k), got_ovf[k], lst && OvfEn && exp_ovf);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " strobe"}, bus_if.cluster_strobe, 0);
    check({tag, " found"}, bus_if.cluster_found, 0);
    check({tag, " adr"}, bus_if.adr, AllOnes);
    check({tag, " cnt"}, bus_if.cnt, 0);
    check({tag, " last"}, bus_if.last, 0);
    check({tag, " ovf"}, bus_if.overflow, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    tbl[0] = '{lo: 1,   hi: 0,   step: 1,   pass: 3'd5, exp_n: 1, exp_first: 'h7FF, exp_last: 'h7FF,
               exp_ovf: 0};
    tbl[1] = '{lo: 0,   hi: 11,  step: 1,   pass: 3'd1, exp_n: 8, exp_first: 0,   exp_last: 7,
               exp_ovf: 1};
    tbl[2] = '{lo: 0,   hi: 7,   step: 1,   pass: 3'd2, exp_n: 8, exp_first: 0,   exp_last: 7,
               exp_ovf: 0};
    tbl[3] = '{lo: 760, hi: 767, step: 7,   pass: 3'd3, exp_n: 2, exp_first: 760, exp_last: 767,
               exp_ovf: 0};
    tbl[4] = '{lo: 767, hi: 767, step: 1,   pass: 3'd4, exp_n: 1, exp_first: 767, exp_last: 767,
               exp_ovf: 0};
    tbl[5] = '{lo: 3,   hi: 765, step: 100, pass: 3'd6, exp_n: 8, exp_first: 3,   exp_last: 703,
               exp_ovf: 0};
    tbl[6] = '{lo: 0,   hi: 767, step: 50,  pass: 3'd7, exp_n: 8, exp_first: 0,   exp_last: 350,
               exp_ovf: 1};

    clock = 1'b0;
    reset = 1'b1;
    bus_if.vpfs_in = '0;
    bus_if.cnts_in = '0;
    bus_if.pass_in = '0;
    // Reset must win over a coincident latch.
    bus_if.vpfs_in[4] = 1'b1;
    bus_if.latch_pulse = 1'b1;
    tick(); tick();
    reset = 1'b0;
    bus_if.latch_pulse = 1'b0;
    check_idle("reset");
    check("reset busy", bus_if.busy, 0);
    check("reset idx", bus_if.cluster_idx, 0);
    check("reset pass", bus_if.pass_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_reset strobe%0d", i), bus_if.cluster_strobe, 0);
    end

    // Table-driven events.
    foreach (tbl[t]) begin
      string nm;
      nm = $sformatf("tbl%0d", t);
      vv = '0; cc = '0;
      for (int i = tbl[t].lo; i <= tbl[t].hi; i += tbl[t].step) begin
        vv[i] = 1'b1;
        cc[i*C +: C] = C'(i * 5 + 1);
      end
      model(vv, cc);
      do_latch(vv, cc, tbl[t].pass);
      collect(nm, 1'b0);
      compare(nm, tbl[t].pass);
      check({nm, " n_const"}, got_adr.size(), tbl[t].exp_n);
      if (got_adr.size() > 0) begin
        check({nm, " first_const"}, got_adr[0], tbl[t].exp_first);
        check({nm, " last_const"}, got_adr[got_adr.size()-1], tbl[t].exp_last);
        check({nm, " ovf_const"}, got_ovf[got_ovf.size()-1], OvfEn && tbl[t].exp_ovf);
      end
      tick();
      check_idle({nm, " after"});
    end

    // Pads 3/100/767 with counts 1/4/7, cycle by cycle.
    vv = '0; cc = '0;
    vv[3] = 1'b1;   cc[3*C +: C] = 3'd1;
    vv[100] = 1'b1; cc[100*C +: C] = 3'd4;
    vv[767] = 1'b1; cc[767*C +: C] = 3'd7;
    do_latch(vv, cc, 3'd2);
    check("seq T+1 busy", bus_if.busy, 1);
    check("seq T+1 strobe", bus_if.cluster_strobe, 0);
    tick();
    check("seq T+2 adr", bus_if.adr, 3);
    check("seq T+2 cnt", bus_if.cnt, 1);
    check("seq T+2 idx", bus_if.cluster_idx, 0);
    check("seq T+2 last", bus_if.last, 0);
    tick();
    check("seq T+3 adr", bus_if.adr, 100);
    check("seq T+3 cnt", bus_if.cnt, 4);
    check("seq T+3 idx", bus_if.cluster_idx, 1);
    tick();
    check("seq T+4 adr", bus_if.adr, 767);
    check("seq T+4 cnt", bus_if.cnt, 7);
    check("seq T+4 idx", bus_if.cluster_idx, 2);
    check("seq T+4 last", bus_if.last, 1);
    check("seq T+4 busy", bus_if.busy, 0);
    tick();
    check("seq T+5 busy", bus_if.busy, 0);
    check_idle("seq T+5");
    check("seq T+5 idx hold", bus_if.cluster_idx, 2);
    check("seq T+5 pass hold", bus_if.pass_out, 2);

    // Event B preempts event A after A's first word.
    vv = '0; cc = '0;
    vv[10] = 1'b1; vv[20] = 1'b1;
    do_latch(vv, cc, 3'd1);
    tick();
    check("preempt A adr", bus_if.adr, 10);
    check("preempt A strobe", bus_if.cluster_strobe, 1);
    vv = '0;
    vv[5] = 1'b1;
    do_latch(vv, cc, 3'd6);
    check("preempt gap strobe", bus_if.cluster_strobe, 0);
    check("preempt gap busy", bus_if.busy, 1);
    tick();
    check("preempt B strobe", bus_if.cluster_strobe, 1);
    check("preempt B adr", bus_if.adr, 5);
    check("preempt B idx", bus_if.cluster_idx, 0);
    check("preempt B last", bus_if.last, 1);
    check("preempt B pass", bus_if.pass_out, 6);
    tick();
    check("preempt after strobe", bus_if.cluster_strobe, 0);

    // Latch in the cycle that presents the last word.
    vv = '0;
    vv[1] = 1'b1; vv[2] = 1'b1;
    do_latch(vv, cc, 3'd3);
    tick();
    tick();
    check("b2b last adr", bus_if.adr, 2);
    check("b2b last last", bus_if.last, 1);
    vv = '0;
    vv[9] = 1'b1;
    do_latch(vv, cc, 3'd4);
    check("b2b T+1 busy", bus_if.busy, 1);
    check("b2b T+1 strobe", bus_if.cluster_strobe, 0);
    tick();
    check("b2b T+2 adr", bus_if.adr, 9);
    check("b2b T+2 strobe", bus_if.cluster_strobe, 1);
    check("b2b T+2 last", bus_if.last, 1);
    check("b2b T+2 pass", bus_if.pass_out, 4);
    tick();

    // Reset in the middle of a search.
    vv = '0;
    vv[1] = 1'b1; vv[2] = 1'b1; vv[3] = 1'b1;
    do_latch(vv, cc, 3'd5);
    tick();
    check("rst_mid word adr", bus_if.adr, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid busy", bus_if.busy, 0);
    check_idle("rst_mid");
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst_mid quiet%0d", i), bus_if.cluster_strobe, 0);
    end

    // Randomized events; inputs are scrambled between latches to prove they are ignored.
    for (int e = 0; e < 40; e++) begin
      int npads;
      logic [PB-1:0] p;
      string nm;
      nm = $sformatf("rnd%0d", e);
      vv = '0;
      npads = $urandom_range(0, 12);
      for (int k = 0; k < npads; k++) vv[$urandom_range(0, P - 1)] = 1'b1;
      for (int j = 0; j < int'(P * C) / 32; j++) cc[j*32 +: 32] = $urandom();
      p = PB'($urandom_range(0, 7));
      model(vv, cc);
      do_latch(vv, cc, p);
      collect(nm, 1'b1);
      compare(nm, p);
      tick();
      check({nm, " idle strobe"}, bus_if.cluster_strobe, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
